sdcard_block_writer_fsm: RTL

- Write-direction counterpart of the SD card block-read FSM in SPI mode.
- Issues CMD24 (single-block write) or CMD25 (multiple-block write) through the shared SD command engine.
- Streams 512-byte data blocks framed with start tokens and CRC bytes, checks the card's data-response token and polls busy.
- Multi-block mode ends with the stop-tran token. Uses the same byte-wide SPI engine and command-engine handshakes as the reader; chip select stays owned by the init/read FSM, which holds it low once the card is configured.

---
 rtl/sdcard_block_writer_fsm_pkg.sv | 51 +++++
 rtl/sdcard_crc16.sv | 28 ++
 rtl/sdcard_block_writer_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_block_writer_fsm_pkg.sv
// Shared SD card SPI constants, writer states/error codes and the CRC16 byte-update helper.
package sdcard_block_writer_fsm_pkg;

  localparam int SD_BLOCK_ADDR_BITS   = 32;
  localparam int SD_BLOCK_LENGHT_BITS = 9;
  localparam int CMD_BITS             = 6;
  localparam int CMD_RESP_BITS        = 40;
  localparam int SPI_SIZE             = 8;

  localparam logic [CMD_BITS-1:0] NOCMD = 6'd63;
  localparam logic [CMD_BITS-1:0] CMD24 = 6'd24;
  localparam logic [CMD_BITS-1:0] CMD25 = 6'd25;

  localparam logic [7:0] TOK_SINGLE = 8'hFE;
  localparam logic [7:0] TOK_MULTI  = 8'hFC;
  localparam logic [7:0] TOK_STOP   = 8'hFD;
  localparam logic [7:0] IDLE_BYTE  = 8'hFF;

  localparam logic [4:0] DRESP_ACCEPTED  = 5'h05;
  localparam logic [4:0] DRESP_CRC_ERR   = 5'h0B;
  localparam logic [4:0] DRESP_WRITE_ERR = 5'h0D;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD_WAIT, ST_CHK_R1, ST_GAP, ST_TOKEN, ST_DATA_REQ, ST_DATA_WAIT,
    ST_DATA_XFER, ST_CRC_HI, ST_CRC_LO, ST_RESP, ST_BUSY, ST_NEXT, ST_STOP,
    ST_STOP_GAP, ST_STOP_BUSY
  } wr_state_e;

  typedef enum logic [2:0] {
    WR_ERR_NONE    = 3'd0,
    WR_ERR_R1      = 3'd1,
    WR_ERR_CRC     = 3'd2,
    WR_ERR_WRITE   = 3'd3,
    WR_ERR_TIMEOUT = 3'd4,
    WR_ERR_NO_RESP = 3'd5
  } wr_err_e;

  typedef enum logic [1:0] {SPI_PH_IDLE, SPI_PH_REQ, SPI_PH_WAIT} spi_phase_e;

  // CRC16-CCITT (poly 0x1021), MSB of the data byte shifted in first.
  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sdcard_crc16.sv
// Byte-wide CRC16-CCITT accumulator; clear has priority over enable.
module sdcard_crc16
  import sdcard_block_writer_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i)   crc_d = 16'h0000;
    else if (en_i) crc_d = crc16Byte(crc_q, data_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) crc_q <= 16'h0000;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdcard_block_writer_fsm.sv
// SPI-mode SD card block writer (CMD24/CMD25) with data-response check and busy polling.
// Define SDCARD_WRITER_CRC16_EN to send a real CRC16 instead of 0xFF 0xFF.
module sdcard_block_writer_fsm
  import sdcard_block_writer_fsm_pkg::*;
#(
  parameter int SD_BLOCK_LENGTH_BYTES = 512,
  parameter int BUSY_TIMEOUT_BYTES    = 65535,
  parameter int RESP_WAIT_BYTES       = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            card_configured,
  input  logic                            block_write_trigger,
  input  logic                            block_write_multi_mode,
  input  logic [SD_BLOCK_ADDR_BITS-1:0]   block_write_block_addr,
  input  logic [7:0]                      block_write_data_in,
  input  logic                            block_write_data_valid,
  output logic                            block_write_data_req,
  output logic [SD_BLOCK_LENGHT_BITS-1:0] block_write_data_idx,
  output logic                            block_write_card_ready,
  output logic                            block_write_done,
  output logic [2:0]                      block_write_error,
  input  logic                            cmd_ready,
  output logic [CMD_BITS-1:0]             cmd_req_idx,
  output logic [SD_BLOCK_ADDR_BITS-1:0]   cmd_block_addr,
  input  logic [CMD_RESP_BITS-1:0]        cmd_response_bytes,
  input  logic                            spi_ready,
  output logic                            spi_req,
  output logic [SPI_SIZE-1:0]             spi_tx_data,
  input  logic [SPI_SIZE-1:0]             spi_rx_data
);

  localparam logic [SD_BLOCK_LENGHT_BITS-1:0] BLOCK_LAST =
    SD_BLOCK_LENGHT_BITS'(SD_BLOCK_LENGTH_BYTES - 1);
  localparam logic [15:0] RESP_LAST = 16'(RESP_WAIT_BYTES - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT_BYTES - 1);

  wr_state_e                       state_q, state_d;
  spi_phase_e                      phase_q, phase_d;
  wr_err_e                         error_q, error_d;
  logic                            spiReq_q, spiReq_d;
  logic [SPI_SIZE-1:0]             spiTx_q, spiTx_d;
  logic [CMD_BITS-1:0]             cmdReq_q, cmdReq_d;
  logic [SD_BLOCK_ADDR_BITS-1:0]   cmdAddr_q, cmdAddr_d;
  logic                            dataReq_q, dataReq_d;
  logic [SD_BLOCK_LENGHT_BITS-1:0] dataIdx_q, dataIdx_d;
  logic [SD_BLOCK_LENGHT_BITS-1:0] byteCnt_q, byteCnt_d;
  logic                            done_q, done_d;
  logic                            multi_q, multi_d;
  logic [15:0]                     pollCnt_q, pollCnt_d;
  logic [7:0]                      dataByte_q, dataByte_d;

  logic        useSpi, byteDone, crcClear, crcEn;
  logic [7:0]  txByte, crcHi, crcLo;
  logic [15:0] crcValue;
  logic        unusedResp;

  assign unusedResp = ^cmd_response_bytes[CMD_RESP_BITS-1:8];

  sdcard_crc16 u_crc16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (crcClear),
    .en_i    (crcEn),
    .data_i  (dataByte_q),
    .crc_o   (crcValue)
  );

`ifdef SDCARD_WRITER_CRC16_EN
  assign crcHi = crcValue[15:8];
  assign crcLo = crcValue[7:0];
`else
  logic unusedCrc;
  assign unusedCrc = ^crcValue;
  assign crcHi     = 8'hFF;
  assign crcLo     = 8'hFF;
`endif

  // Byte-sending states and what they put on MOSI.
  always_comb begin
    useSpi = 1'b1;
    txByte = IDLE_BYTE;
    case (state_q)
      ST_TOKEN:     txByte = multi_q ? TOK_MULTI : TOK_SINGLE;
      ST_DATA_XFER: txByte = dataByte_q;
      ST_CRC_HI:    txByte = crcHi;
      ST_CRC_LO:    txByte = crcLo;
      ST_STOP:      txByte = TOK_STOP;
      ST_GAP, ST_RESP, ST_BUSY, ST_STOP_GAP, ST_STOP_BUSY: ;
      default:      useSpi = 1'b0;
    endcase
  end

  assign byteDone = (phase_q == SPI_PH_WAIT) && spi_ready;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    error_d    = error_q;
    spiReq_d   = spiReq_q;
    spiTx_d    = spiTx_q;
    cmdReq_d   = cmdReq_q;
    cmdAddr_d  = cmdAddr_q;
    dataReq_d  = 1'b0;
    dataIdx_d  = dataIdx_q;
    byteCnt_d  = byteCnt_q;
    done_d     = 1'b0;
    multi_d    = multi_q;
    pollCnt_d  = pollCnt_q;
    dataByte_d = dataByte_q;
    crcClear   = 1'b0;
    crcEn      = 1'b0;

    case (phase_q)
      SPI_PH_IDLE: if (useSpi && spi_ready) begin
        spiReq_d = 1'b1;
        spiTx_d  = txByte;
        phase_d  = SPI_PH_REQ;
      end
      SPI_PH_REQ: if (!spi_ready) begin
        spiReq_d = 1'b0;
        phase_d  = SPI_PH_WAIT;
      end
      SPI_PH_WAIT: if (spi_ready) phase_d = SPI_PH_IDLE;
      default: phase_d = SPI_PH_IDLE;
    endcase

    case (state_q)
      ST_IDLE: if (block_write_trigger && card_configured) begin
        multi_d   = block_write_multi_mode;
        cmdAddr_d = block_write_block_addr;
        error_d   = WR_ERR_NONE;
        cmdReq_d  = block_write_multi_mode ? CMD25 : CMD24;
        state_d   = ST_CMD_WAIT;
      end
      ST_CMD_WAIT: if (!cmd_ready) begin
        cmdReq_d = NOCMD;
        state_d  = ST_CHK_R1;
      end
      ST_CHK_R1: if (cmd_ready) begin
        if (cmd_response_bytes[7:0] != 8'h00) begin
          error_d = WR_ERR_R1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: if (byteDone) state_d = ST_TOKEN;
      ST_TOKEN: begin
        crcClear = 1'b1;
        if (byteDone) begin
          byteCnt_d = '0;
          state_d   = ST_DATA_REQ;
        end
      end
      ST_DATA_REQ: begin
        dataReq_d = 1'b1;
        dataIdx_d = byteCnt_q;
        state_d   = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: if (block_write_data_valid) begin
        dataByte_d = block_write_data_in;
        state_d    = ST_DATA_XFER;
      end
      ST_DATA_XFER: if (byteDone) begin
        crcEn = 1'b1;
        if (byteCnt_q == BLOCK_LAST) begin
          state_d = ST_CRC_HI;
        end else begin
          byteCnt_d = byteCnt_q + 1'b1;
          state_d   = ST_DATA_REQ;
        end
      end
      ST_CRC_HI: if (byteDone) state_d = ST_CRC_LO;
      ST_CRC_LO: if (byteDone) begin
        pollCnt_d = '0;
        state_d   = ST_RESP;
      end
      ST_RESP: if (byteDone) begin
        if (spi_rx_data == 8'hFF && pollCnt_q != RESP_LAST) begin
          pollCnt_d = pollCnt_q + 1'b1;
        end else begin
          if (spi_rx_data == 8'hFF)                 error_d = WR_ERR_NO_RESP;
          else if (spi_rx_data[4:0] == DRESP_CRC_ERR)  error_d = WR_ERR_CRC;
          else if (spi_rx_data[4:0] != DRESP_ACCEPTED) error_d = WR_ERR_WRITE;
          pollCnt_d = '0;
          state_d   = ST_BUSY;
        end
      end
      // Timeout skips the stop token: the card is presumed wedged.
      ST_BUSY, ST_STOP_BUSY: if (byteDone) begin
        if (spi_rx_data != 8'h00) begin
          if (state_q == ST_BUSY && multi_q) begin
            state_d = (error_q != WR_ERR_NONE) ? ST_STOP : ST_NEXT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (pollCnt_q == BUSY_LAST) begin
          error_d = WR_ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pollCnt_d = pollCnt_q + 1'b1;
        end
      end
      ST_NEXT: state_d = block_write_trigger ? ST_GAP : ST_STOP;
      ST_STOP: if (byteDone) state_d = ST_STOP_GAP;
      ST_STOP_GAP: if (byteDone) begin
        pollCnt_d = '0;
        state_d   = ST_STOP_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= SPI_PH_IDLE;
      error_q    <= WR_ERR_NONE;
      spiReq_q   <= 1'b0;
      spiTx_q    <= 8'hFF;
      cmdReq_q   <= NOCMD;
      cmdAddr_q  <= '0;
      dataReq_q  <= 1'b0;
      dataIdx_q  <= '0;
      byteCnt_q  <= '0;
      done_q     <= 1'b0;
      multi_q    <= 1'b0;
      pollCnt_q  <= '0;
      dataByte_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      error_q    <= error_d;
      spiReq_q   <= spiReq_d;
      spiTx_q    <= spiTx_d;
      cmdReq_q   <= cmdReq_d;
      cmdAddr_q  <= cmdAddr_d;
      dataReq_q  <= dataReq_d;
      dataIdx_q  <= dataIdx_d;
      byteCnt_q  <= byteCnt_d;
      done_q     <= done_d;
      multi_q    <= multi_d;
      pollCnt_q  <= pollCnt_d;
      dataByte_q <= dataByte_d;
    end
  end

  assign spi_req                = spiReq_q;
  assign spi_tx_data            = spiTx_q;
  assign cmd_req_idx            = cmdReq_q;
  assign cmd_block_addr         = cmdAddr_q;
  assign block_write_data_req   = dataReq_q;
  assign block_write_data_idx   = dataIdx_q;
  assign block_write_done       = done_q;
  assign block_write_error      = error_q;
  assign block_write_card_ready = (state_q == ST_IDLE) && card_configured;

endmodule
